// File: rtl/mcu_pkg.sv
// Shared fetch-stage types: FSM states, instruction length encoding and
// the opcode[7:6] length-class decode.
package mcu_pkg;

  typedef enum logic [1:0] {
    FETCH_OP = 2'd0,
    FETCH_LO = 2'd1,
    FETCH_HI = 2'd2,
    HOLD     = 2'd3
  } fetch_state_e;

  localparam logic [1:0] LEN_1 = 2'd1;
  localparam logic [1:0] LEN_2 = 2'd2;
  localparam logic [1:0] LEN_3 = 2'd3;

  localparam logic [1:0] OPC_CLASS_1B = 2'b00;
  localparam logic [1:0] OPC_CLASS_2B = 2'b01;

  function automatic logic [1:0] decode_len(input logic [7:0] opcode);
    logic [1:0] len;
    case (opcode[7:6])
      OPC_CLASS_1B: len = LEN_1;
      OPC_CLASS_2B: len = LEN_2;
      default:      len = LEN_3;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/instr_fetch_counter.sv
// Loadable up-counter used as the fetch PC; load wins over increment and
// the count wraps naturally at the top of its range.
module instr_fetch_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: load, increment or hold
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Byte-serial instruction fetch: reads a 1..3 byte instruction from program
// memory, assembles it and holds it for the decode stage until accepted.
module instr_fetch
  import mcu_pkg::*;
#(
  parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  input  logic        jump_valid,
  input  logic [15:0] jump_addr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [7:0]  instr_opcode,
  output logic [15:0] instr_operand,
  output logic [1:0]  instr_len,
  output logic [15:0] instr_pc
);

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_s;
  logic         mem_req_s;
  logic         instr_valid_s;
  logic [7:0]   op_q;
  logic [7:0]   lo_q;
  logic [15:0]  start_pc_q;
  logic [7:0]   opcode_q;
  logic [15:0]  operand_q;
  logic [1:0]   len_q;
  logic [15:0]  ipc_q;

  instr_fetch_counter #(.W(16)) u_pc (
    .clk        (clk),
    .load_i     (jump_valid | rst),
    .load_val_i (rst ? RESET_VECTOR : jump_addr),
    .en_i       (mem_req_s & mem_ack),
    .count_o    (pc_s)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH_OP;
    else     state_q <= state_d;
  end

  // Next-state logic; a redirect restarts the fetch from any state
  always_comb begin
    state_d = state_q;
    if (jump_valid) begin
      state_d = FETCH_OP;
    end else begin
      case (state_q)
        FETCH_OP: if (mem_ack) state_d = (decode_len(mem_rdata) == LEN_1) ? HOLD : FETCH_LO;
                  else         state_d = FETCH_OP;
        FETCH_LO: if (mem_ack) state_d = (decode_len(op_q) == LEN_2) ? HOLD : FETCH_HI;
                  else         state_d = FETCH_LO;
        FETCH_HI: if (mem_ack) state_d = HOLD;
                  else         state_d = FETCH_HI;
        HOLD:     if (instr_ready) state_d = FETCH_OP;
                  else             state_d = HOLD;
        default:  state_d = FETCH_OP;
      endcase
    end
  end

  // Output decode; reset masks the request and valid immediately
  always_comb begin
    mem_req_s     = 1'b0;
    instr_valid_s = 1'b0;
    if (rst) begin
      mem_req_s     = 1'b0;
      instr_valid_s = 1'b0;
    end else begin
      mem_req_s     = (state_q != HOLD);
      instr_valid_s = (state_q == HOLD);
    end
  end

  // Byte staging and instruction registers, loaded only on the final byte
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= 8'h00;
      lo_q       <= 8'h00;
      start_pc_q <= 16'h0000;
      opcode_q   <= 8'h00;
      operand_q  <= 16'h0000;
      len_q      <= 2'd0;
      ipc_q      <= 16'h0000;
    end else if (!jump_valid && mem_req_s && mem_ack) begin
      case (state_q)
        FETCH_OP: begin
          op_q       <= mem_rdata;
          start_pc_q <= pc_s;
          if (decode_len(mem_rdata) == LEN_1) begin
            opcode_q  <= mem_rdata;
            operand_q <= 16'h0000;
            len_q     <= LEN_1;
            ipc_q     <= pc_s;
          end
        end
        FETCH_LO: begin
          lo_q <= mem_rdata;
          if (decode_len(op_q) == LEN_2) begin
            opcode_q  <= op_q;
            operand_q <= {8'h00, mem_rdata};
            len_q     <= LEN_2;
            ipc_q     <= start_pc_q;
          end
        end
        FETCH_HI: begin
          opcode_q  <= op_q;
          operand_q <= {mem_rdata, lo_q};
          len_q     <= LEN_3;
          ipc_q     <= start_pc_q;
        end
        default: op_q <= op_q;
      endcase
    end
  end

  assign mem_req       = mem_req_s;
  assign mem_addr      = pc_s;
  assign instr_valid   = instr_valid_s;
  assign instr_opcode  = opcode_q;
  assign instr_operand = operand_q;
  assign instr_len     = len_q;
  assign instr_pc      = ipc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch with a byte memory model that has a
// programmable number of wait cycles per read.
module tb_instr_fetch;

  typedef struct packed {
    logic [7:0]  op;
    logic [15:0] opd;
    logic [1:0]  len;
    logic [15:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, mem_req, mem_ack, jump_valid, instr_valid, instr_ready;
  logic [15:0] mem_addr, jump_addr, instr_operand, instr_pc;
  logic [7:0]  mem_rdata, instr_opcode;
  logic [1:0]  instr_len;

  logic [7:0] mem [0:65535];
  int   wait_cfg = 0;
  int   wait_cnt = 0;
  exp_t sb_q[$];
  exp_t exp_v;
  exp_t cur_exp;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc;

  instr_fetch #(.RESET_VECTOR(16'h0000)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .jump_valid(jump_valid),
    .jump_addr(jump_addr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opcode(instr_opcode), .instr_operand(instr_operand),
    .instr_len(instr_len), .instr_pc(instr_pc)
  );

  always #5 clk = ~clk;

  assign mem_ack   = mem_req && (wait_cnt == wait_cfg);
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (!mem_req || mem_ack || jump_valid) wait_cnt <= 0;
    else                                   wait_cnt <= wait_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int c);
    c = 0;
    while (!instr_valid && c < 50) begin
      tick();
      c++;
    end
    if (!instr_valid) c = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; jump_valid = 1'b0; jump_addr = 16'h0000; instr_ready = 1'b0;
    tick(); tick();
    n_vec++;
    if ({mem_req, instr_valid} !== 2'b00) begin
      n_err++; $display("FAIL reset_ctrl: got req/valid=%b required 00", {mem_req, instr_valid});
    end
    n_vec++;
    if ({instr_opcode, instr_operand, instr_len, instr_pc} !== 42'd0) begin
      n_err++; $display("FAIL reset_fields: got %h required 0", {instr_opcode, instr_operand, instr_len, instr_pc});
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if ({mem_req, mem_addr} !== {1'b1, 16'h0000}) begin
      n_err++; $display("FAIL reset_release: got req=%b addr=%h required 1/0000", mem_req, mem_addr);
    end
  endtask

  task automatic test_single_byte();
    sb_q.push_back('{op: 8'h05, opd: 16'h0000, len: 2'd1, pc: 16'h0000});
    wait_valid(cyc);
    n_vec++;
    if (cyc != 1) begin n_err++; $display("FAIL single_latency: got %0d cycles required 1", cyc); end
    n_vec++;
    if (sb_q.size() == 0) begin n_err++; $display("FAIL single_fields: got output with empty scoreboard"); end
    else begin
      exp_v = sb_q.pop_front();
      if ({instr_opcode, instr_operand, instr_len, instr_pc} !== exp_v) begin
        n_err++; $display("FAIL single_fields: got %h required %h", {instr_opcode, instr_operand, instr_len, instr_pc}, exp_v);
      end
    end
    instr_ready = 1'b1; tick(); instr_ready = 1'b0;
    n_vec++;
    if ({instr_valid, mem_addr} !== {1'b0, 16'h0001}) begin
      n_err++; $display("FAIL single_next: got valid=%b addr=%h required 0/0001", instr_valid, mem_addr);
    end
  endtask

  task automatic test_three_byte();
    mem[16'h0010] = 8'h80; mem[16'h0011] = 8'h34; mem[16'h0012] = 8'h12;
    sb_q.push_back('{op: 8'h80, opd: 16'h1234, len: 2'd3, pc: 16'h0010});
    jump_addr = 16'h0010; jump_valid = 1'b1; tick(); jump_valid = 1'b0;
    wait_valid(cyc);
    n_vec++;
    if (cyc != 3) begin n_err++; $display("FAIL three_latency: got %0d cycles required 3", cyc); end
    n_vec++;
    if (sb_q.size() == 0) begin n_err++; $display("FAIL three_fields: got output with empty scoreboard"); end
    else begin
      exp_v = sb_q.pop_front();
      if ({instr_opcode, instr_operand, instr_len, instr_pc} !== exp_v) begin
        n_err++; $display("FAIL three_fields: got %h required %h", {instr_opcode, instr_operand, instr_len, instr_pc}, exp_v);
      end
    end
    instr_ready = 1'b1; tick(); instr_ready = 1'b0;
    n_vec++;
    if (mem_addr !== 16'h0013) begin n_err++; $display("FAIL three_next: got addr=%h required 0013", mem_addr); end
  endtask

  task automatic test_wait_states();
    mem[16'h0020] = 8'h40; mem[16'h0021] = 8'hAB;
    wait_cfg = 2;
    sb_q.push_back('{op: 8'h40, opd: 16'h00AB, len: 2'd2, pc: 16'h0020});
    jump_addr = 16'h0020; jump_valid = 1'b1; tick(); jump_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_vec++;
      if ({mem_req, mem_addr} !== {1'b1, (i < 3) ? 16'h0020 : 16'h0021}) begin
        n_err++; $display("FAIL wait_addr[%0d]: got req=%b addr=%h required 1/%h", i, mem_req, mem_addr, (i < 3) ? 16'h0020 : 16'h0021);
      end
      tick();
    end
    n_vec++;
    if (instr_valid !== 1'b1) begin n_err++; $display("FAIL wait_valid: got %b required 1", instr_valid); end
    n_vec++;
    if (sb_q.size() == 0) begin n_err++; $display("FAIL wait_fields: got output with empty scoreboard"); end
    else begin
      cur_exp = sb_q.pop_front();
      if ({instr_opcode, instr_operand, instr_len, instr_pc} !== cur_exp) begin
        n_err++; $display("FAIL wait_fields: got %h required %h", {instr_opcode, instr_operand, instr_len, instr_pc}, cur_exp);
      end
    end
  endtask

  task automatic test_hold_stall();
    for (int i = 0; i < 5; i++) begin
      tick();
      n_vec++;
      if ({instr_valid, mem_req, mem_addr} !== {1'b1, 1'b0, 16'h0022}) begin
        n_err++; $display("FAIL stall_ctrl[%0d]: got valid=%b req=%b addr=%h required 1/0/0022", i, instr_valid, mem_req, mem_addr);
      end
      n_vec++;
      if ({instr_opcode, instr_operand, instr_len, instr_pc} !== cur_exp) begin
        n_err++; $display("FAIL stall_fields[%0d]: got %h required %h", i, {instr_opcode, instr_operand, instr_len, instr_pc}, cur_exp);
      end
    end
    wait_cfg = 0;
    instr_ready = 1'b1; tick(); instr_ready = 1'b0;
    n_vec++;
    if ({instr_valid, mem_addr} !== {1'b0, 16'h0022}) begin
      n_err++; $display("FAIL stall_release: got valid=%b addr=%h required 0/0022", instr_valid, mem_addr);
    end
  endtask

  task automatic test_jump_abort();
    mem[16'h0030] = 8'hC0; mem[16'h0031] = 8'h11; mem[16'h2000] = 8'h00;
    jump_addr = 16'h0030; jump_valid = 1'b1; tick(); jump_valid = 1'b0;
    tick();
    n_vec++;
    if (mem_addr !== 16'h0031) begin n_err++; $display("FAIL abort_lo_addr: got %h required 0031", mem_addr); end
    jump_addr = 16'h2000; jump_valid = 1'b1; tick(); jump_valid = 1'b0;
    n_vec++;
    if ({instr_valid, mem_addr} !== {1'b0, 16'h2000}) begin
      n_err++; $display("FAIL abort_redirect: got valid=%b addr=%h required 0/2000", instr_valid, mem_addr);
    end
    sb_q.push_back('{op: 8'h00, opd: 16'h0000, len: 2'd1, pc: 16'h2000});
    wait_valid(cyc);
    n_vec++;
    if (cyc != 1) begin n_err++; $display("FAIL abort_latency: got %0d cycles required 1", cyc); end
    n_vec++;
    if (sb_q.size() == 0) begin n_err++; $display("FAIL abort_fields: got output with empty scoreboard"); end
    else begin
      exp_v = sb_q.pop_front();
      if ({instr_opcode, instr_operand, instr_len, instr_pc} !== exp_v) begin
        n_err++; $display("FAIL abort_fields: got %h required %h", {instr_opcode, instr_operand, instr_len, instr_pc}, exp_v);
      end
    end
    // Redirect coinciding with the handshake consumes the held instruction
    jump_addr = 16'h0040; jump_valid = 1'b1; instr_ready = 1'b1; tick();
    jump_valid = 1'b0; instr_ready = 1'b0;
    n_vec++;
    if ({instr_valid, mem_req, mem_addr} !== {1'b0, 1'b1, 16'h0040}) begin
      n_err++; $display("FAIL jump_handshake: got valid=%b req=%b addr=%h required 0/1/0040", instr_valid, mem_req, mem_addr);
    end
  endtask

  task automatic test_wrap_reset();
    mem[16'hFFFF] = 8'h81; mem[16'h0000] = 8'hCD; mem[16'h0001] = 8'hAB;
    sb_q.push_back('{op: 8'h81, opd: 16'hABCD, len: 2'd3, pc: 16'hFFFF});
    jump_addr = 16'hFFFF; jump_valid = 1'b1; tick(); jump_valid = 1'b0;
    wait_valid(cyc);
    n_vec++;
    if (cyc != 3) begin n_err++; $display("FAIL wrap_latency: got %0d cycles required 3", cyc); end
    n_vec++;
    if (sb_q.size() == 0) begin n_err++; $display("FAIL wrap_fields: got output with empty scoreboard"); end
    else begin
      exp_v = sb_q.pop_front();
      if ({instr_opcode, instr_operand, instr_len, instr_pc} !== exp_v) begin
        n_err++; $display("FAIL wrap_fields: got %h required %h", {instr_opcode, instr_operand, instr_len, instr_pc}, exp_v);
      end
    end
    instr_ready = 1'b1; tick(); instr_ready = 1'b0;
    n_vec++;
    if (mem_addr !== 16'h0002) begin n_err++; $display("FAIL wrap_next: got addr=%h required 0002", mem_addr); end
    jump_addr = 16'hFFFF; jump_valid = 1'b1; tick(); jump_valid = 1'b0;
    tick(); tick();
    n_vec++;
    if ({mem_req, mem_addr} !== {1'b1, 16'h0001}) begin
      n_err++; $display("FAIL wrap_hi_addr: got req=%b addr=%h required 1/0001", mem_req, mem_addr);
    end
    rst = 1'b1; tick();
    n_vec++;
    if ({mem_req, instr_valid} !== 2'b00) begin
      n_err++; $display("FAIL midreset_ctrl: got req/valid=%b required 00", {mem_req, instr_valid});
    end
    n_vec++;
    if ({instr_opcode, instr_operand, instr_len, instr_pc} !== 42'd0) begin
      n_err++; $display("FAIL midreset_fields: got %h required 0", {instr_opcode, instr_operand, instr_len, instr_pc});
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if ({mem_req, mem_addr} !== {1'b1, 16'h0000}) begin
      n_err++; $display("FAIL midreset_release: got req=%b addr=%h required 1/0000", mem_req, mem_addr);
    end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    mem[16'h0000] = 8'h05;
    test_reset();
    test_single_byte();
    test_three_byte();
    test_wait_states();
    test_hold_stall();
    test_jump_abort();
    test_wrap_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1);
  end

endmodule
